// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: default widths
// and the sequencer state encoding.
package fetch_sequencer_pkg;

    localparam int FS_ADDR_W  = 10;
    localparam int FS_INSTR_W = 16;
    localparam int FS_STAT_W  = 16;

    typedef logic [1:0] fs_state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

endpackage

// File: rtl/fetch_stat_counter.sv
// Saturating event counter with synchronous clear, used for the optional
// fetch statistics. Only compiled when FETCH_STATS_EN is defined.
`ifdef FETCH_STATS_EN
module fetch_stat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear has priority; increments stop at all-ones
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {W{1'b0}};
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC register controls and the req/ack
// instruction-memory handshake, buffers one fetched word for decode, and
// handles execute redirects, wrong-path squashing and halt.
// Optional build macro FETCH_STATS_EN adds stat_fetch/stat_stall counters.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W  = FS_ADDR_W,
    parameter int INSTR_W = FS_INSTR_W
`ifdef FETCH_STATS_EN
    ,
    parameter int STAT_W  = FS_STAT_W
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_branch,
    output logic [ADDR_W-1:0]  pc_br_address,
    output logic               pc_stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               if_ready,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               halt,
    output logic               flush,
    output logic               halted
`ifdef FETCH_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_fetch,
    output logic [STAT_W-1:0]  stat_stall
`endif
);

    fs_state_t            state_q, state_d;
    logic                 imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]    imem_addr_q, imem_addr_d;
    logic                 if_valid_q, if_valid_d;
    logic [INSTR_W-1:0]   if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]    if_pc_q, if_pc_d;
    logic                 kill_q, kill_d;
    logic                 halt_pend_q, halt_pend_d;

    logic                 redirect_s;
    logic                 accept_s;
    logic                 wait_miss_s;

    // Per-cycle events: redirect, fetch accepted into buffer, WAIT without ack
    always_comb begin
        redirect_s  = br_taken && (state_q != ST_IDLE);
        accept_s    = (state_q == ST_WAIT) && imem_ack && !kill_q && !br_taken;
        wait_miss_s = (state_q == ST_WAIT) && !imem_ack;
    end

    // Next-state, fetch handshake and instruction buffer updates
    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        kill_d      = kill_q;
        halt_pend_d = halt_pend_q;
        if_valid_d  = if_valid_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;

        // A redirect squashes the buffer; a refill beats a same-cycle consume
        if (redirect_s) begin
            if_valid_d = 1'b0;
        end else if (accept_s) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_data;
            if_pc_d    = imem_addr_q;
        end else if (if_ready) begin
            if_valid_d = 1'b0;
        end else begin
            if_valid_d = if_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // No issue under a redirect: pc_addr is still the old path
                if (br_taken) begin
                    halt_pend_d = 1'b0;
                end else if (halt_pend_q || halt) begin
                    halt_pend_d = 1'b0;
                    state_d     = ST_HALTED;
                end else if (!if_valid_q || if_ready) begin
                    imem_addr_d = pc_addr;
                    imem_req_d  = 1'b1;
                    state_d     = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // The branch is older than any halt seen alongside it
                if (br_taken) begin
                    halt_pend_d = 1'b0;
                end else if (halt) begin
                    halt_pend_d = 1'b1;
                end else begin
                    halt_pend_d = halt_pend_q;
                end
                // req and addr stay put until ack; a redirect marks the
                // outstanding fetch as wrong-path so its data is dropped
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    kill_d     = 1'b0;
                    state_d    = ST_ISSUE;
                end else if (br_taken) begin
                    kill_d = 1'b1;
                end else begin
                    kill_d = kill_q;
                end
            end
            ST_HALTED: begin
                // Halt wins over a simultaneous start
                if (br_taken || (start && !halt)) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                imem_req_d  = 1'b0;
                kill_d      = 1'b0;
                halt_pend_d = 1'b0;
            end
        endcase
    end

    // Sequencer state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= {ADDR_W{1'b0}};
            if_valid_q  <= 1'b0;
            if_instr_q  <= {INSTR_W{1'b0}};
            if_pc_q     <= {ADDR_W{1'b0}};
            kill_q      <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            kill_q      <= kill_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // Same-cycle PC controls; the PC only advances on an accepted fetch
    always_comb begin
        pc_br_address = br_target;
        if (!reset) begin
            pc_stall  = 1'b1;
            pc_branch = 1'b0;
            flush     = 1'b0;
            halted    = 1'b0;
        end else begin
            pc_stall  = !accept_s;
            pc_branch = redirect_s;
            flush     = redirect_s;
            halted    = (state_q == ST_HALTED);
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;

`ifdef FETCH_STATS_EN
    fetch_stat_counter #(.W(STAT_W)) u_stat_fetch (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .inc   (accept_s),
        .count (stat_fetch)
    );

    fetch_stat_counter #(.W(STAT_W)) u_stat_stall (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .inc   (wait_miss_s),
        .count (stat_stall)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a directed vector table for the
// basic fetch stream, hand sequences for redirect/halt/reset corners, then
// random stimulus compared against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

    localparam int AW = 10;
    localparam int IW = 16;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset, start, imem_ack, if_ready, br_taken, halt;
    logic [AW-1:0] pc_addr, br_target;
    logic [IW-1:0] imem_data;
    logic          pc_branch, pc_stall, imem_req, if_valid, flush, halted;
    logic [AW-1:0] pc_br_address, imem_addr, if_pc;
    logic [IW-1:0] if_instr;
`ifdef FETCH_STATS_EN
    logic [SW-1:0] stat_fetch, stat_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .pc_addr(pc_addr),
        .pc_branch(pc_branch), .pc_br_address(pc_br_address), .pc_stall(pc_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .if_ready(if_ready), .br_taken(br_taken),
        .br_target(br_target), .halt(halt), .flush(flush),
`ifdef FETCH_STATS_EN
        .stat_fetch(stat_fetch), .stat_stall(stat_stall),
`endif
        .halted(halted)
    );

    // Instruction memory contents: a fixed function of the address
    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[5:0], a} ^ 16'hC35A;
    endfunction

    always_comb imem_data = mem_word(imem_addr);

    // The PC register the sequencer controls
    always @(posedge clk) begin
        if (!reset)              pc_addr <= 10'd0;
        else if (pc_branch)      pc_addr <= pc_br_address;
        else if (!pc_stall)      pc_addr <= pc_addr + 10'd1;
    end

    // Behavioural model: running/halted modes, one outstanding fetch
    // (possibly wrong-path), a deferred halt, and the decode buffer
    bit            m_known = 1'b0;
    bit            m_running, m_halted, m_inflight, m_wrong, m_halt_after;
    logic [AW-1:0] m_req_addr;
    bit            m_buf_valid;
    logic [IW-1:0] m_buf_instr;
    logic [AW-1:0] m_buf_pc;
`ifdef FETCH_STATS_EN
    int            m_sf, m_ss;
`endif

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, check every output against the model, advance the model
    task automatic cycle(input logic rst, input logic st, input logic ack, input logic rdy,
                         input logic br, input logic [AW-1:0] tgt, input logic hlt);
        bit redirect, accept, old_valid;
        @(negedge clk);
        reset = rst; start = st; imem_ack = ack; if_ready = rdy;
        br_taken = br; br_target = tgt; halt = hlt;
        #1;
        redirect = rst && br && (m_running || m_halted);
        accept   = rst && m_inflight && ack && !m_wrong && !br;
        chk("pc_stall",  pc_stall,  !accept);
        chk("pc_branch", pc_branch, redirect);
        chk("flush",     flush,     redirect);
        chk("halted",    halted,    rst && m_halted);
        if (redirect) chk("pc_br_address", pc_br_address, tgt);
        if (m_known) begin
            chk("imem_req",  imem_req,  m_inflight);
            chk("imem_addr", imem_addr, m_req_addr);
            chk("if_valid",  if_valid,  m_buf_valid);
            chk("if_pc",     if_pc,     m_buf_pc);
            chk("if_instr",  if_instr,  m_buf_instr);
`ifdef FETCH_STATS_EN
            chk("stat_fetch", stat_fetch, m_sf);
            chk("stat_stall", stat_stall, m_ss);
`endif
        end
        if (!rst) begin
            m_known = 1'b1; m_running = 1'b0; m_halted = 1'b0; m_inflight = 1'b0;
            m_wrong = 1'b0; m_halt_after = 1'b0; m_req_addr = '0;
            m_buf_valid = 1'b0; m_buf_instr = '0; m_buf_pc = '0;
`ifdef FETCH_STATS_EN
            m_sf = 0; m_ss = 0;
`endif
        end else begin
            old_valid = m_buf_valid;
`ifdef FETCH_STATS_EN
            if (st) begin
                m_sf = 0; m_ss = 0;
            end else begin
                if (accept && m_sf < (1 << SW) - 1) m_sf++;
                if (m_inflight && !ack && m_ss < (1 << SW) - 1) m_ss++;
            end
`endif
            if (redirect) m_buf_valid = 1'b0;
            else if (accept) begin
                m_buf_valid = 1'b1; m_buf_instr = mem_word(m_req_addr); m_buf_pc = m_req_addr;
            end else if (rdy) m_buf_valid = 1'b0;
            if (m_inflight) begin
                if (br) m_halt_after = 1'b0;
                else if (hlt) m_halt_after = 1'b1;
                if (ack) begin
                    m_inflight = 1'b0; m_wrong = 1'b0;
                end else if (br) m_wrong = 1'b1;
            end else if (m_running) begin
                if (br) m_halt_after = 1'b0;
                else if (m_halt_after || hlt) begin
                    m_running = 1'b0; m_halted = 1'b1; m_halt_after = 1'b0;
                end else if (!old_valid || rdy) begin
                    m_inflight = 1'b1; m_req_addr = pc_addr;
                end
            end else if (m_halted) begin
                if (br || (st && !hlt)) begin
                    m_halted = 1'b0; m_running = 1'b1;
                end
            end else if (st) begin
                m_running = 1'b1;
            end
        end
    endtask

    typedef struct packed {
        logic          rst, st, ack, rdy, chk_regs;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_valid;
        logic [AW-1:0] e_ifpc;
        logic          e_stall;
    } vec_t;

    vec_t tbl [15];

    initial begin
        reset = 1'b0; start = 1'b0; imem_ack = 1'b0; if_ready = 1'b0;
        br_taken = 1'b0; br_target = '0; halt = 1'b0;

        // rst st ack rdy chk | req addr valid ifpc stall
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,10'd0,1'b0,10'd0,1'b1};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,10'd0,1'b0,10'd0,1'b1};
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, 1'b0,10'd0,1'b0,10'd0,1'b1};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,10'd0,1'b0,10'd0,1'b1};
        tbl[4]  = '{1'b1,1'b0,1'b1,1'b1,1'b1, 1'b1,10'd0,1'b0,10'd0,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,10'd0,1'b1,10'd0,1'b1};
        tbl[6]  = '{1'b1,1'b0,1'b1,1'b1,1'b1, 1'b1,10'd1,1'b0,10'd0,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,10'd1,1'b1,10'd1,1'b1};
        tbl[8]  = '{1'b1,1'b0,1'b1,1'b1,1'b1, 1'b1,10'd2,1'b0,10'd1,1'b0};
        tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,10'd2,1'b1,10'd2,1'b1};
        tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,10'd2,1'b1,10'd2,1'b1};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,10'd2,1'b1,10'd2,1'b1};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,10'd3,1'b0,10'd2,1'b1};
        tbl[13] = '{1'b1,1'b0,1'b1,1'b0,1'b1, 1'b1,10'd3,1'b0,10'd2,1'b0};
        tbl[14] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,10'd3,1'b1,10'd3,1'b1};

        // Reset, start, zero-wait fetch stream, then decode back-pressure
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].rst, tbl[i].st, tbl[i].ack, tbl[i].rdy, 1'b0, 10'd0, 1'b0);
            chk("tbl_pc_stall", pc_stall, tbl[i].e_stall);
            if (tbl[i].chk_regs) begin
                chk("tbl_imem_req",  imem_req,  tbl[i].e_req);
                chk("tbl_imem_addr", imem_addr, tbl[i].e_addr);
                chk("tbl_if_valid",  if_valid,  tbl[i].e_valid);
                chk("tbl_if_pc",     if_pc,     tbl[i].e_ifpc);
                if (tbl[i].e_valid) chk("tbl_if_instr", if_instr, mem_word(tbl[i].e_ifpc));
            end
        end

        // Redirect while waiting on addr 5; the late ack is wrong-path
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h200, 1'b0);
        chk("br_pc_branch", pc_branch, 1'b1);
        chk("br_flush", flush, 1'b1);
        chk("br_address", pc_br_address, 10'h200);
        chk("br_wait_addr", imem_addr, 10'd5);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("br_one_cycle", pc_branch, 1'b0);
        chk("br_req_held", imem_req, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("kill_ack_stall", pc_stall, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
        chk("kill_discard", if_valid, 1'b0);
        // Redirect coinciding with the ack: data dropped, then fetch at 7
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'd7, 1'b0);
        chk("redir_addr", imem_addr, 10'h200);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
        chk("same_ack_valid", if_valid, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'd9, 1'b0);
        chk("addr7", imem_addr, 10'd7);
        chk("addr7_branch", pc_branch, 1'b1);
        // Halt while waiting on addr 9: word 9 lands, then HALTED
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("addr7_dropped", if_valid, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1);
        chk("addr9", imem_addr, 10'd9);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("halt_ack_advance", pc_stall, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("halt_buf_pc", if_pc, 10'd9);
        chk("halt_buf_instr", if_instr, mem_word(10'd9));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("halted_set", halted, 1'b1);
        chk("halted_no_req", imem_req, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("halt_beats_start", halted, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
        chk("resumed", halted, 1'b0);
        chk("halt_buf_kept", if_valid, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("resume_addr", imem_addr, 10'd10);
        chk("resume_req", imem_req, 1'b1);

        // Start clears the statistics; three fetches with two wait cycles each
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
`ifdef FETCH_STATS_EN
        chk("stat_fetch_3", stat_fetch, 16'd3);
        chk("stat_stall_6", stat_stall, 16'd6);
`endif
        // Reset in the middle of a WAIT drops the request
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("pre_reset_req", imem_req, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd3, 1'b0);
        chk("rst_comb_stall", pc_stall, 1'b1);
        chk("rst_comb_branch", pc_branch, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        chk("rst_req_dropped", imem_req, 1'b0);
        chk("rst_buf_cleared", if_valid, 1'b0);
`ifdef FETCH_STATS_EN
        chk("rst_stat_fetch", stat_fetch, 16'd0);
        chk("rst_stat_stall", stat_stall, 16'd0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic r_rst, r_st, r_ack, r_rdy, r_br, r_hlt;
            logic [AW-1:0] r_tgt;
            r_rst = ($urandom_range(0, 299) != 0);
            r_st  = ($urandom_range(0, 15) == 0);
            r_ack = m_inflight ? 1'($urandom_range(0, 1)) : 1'b0;
            r_rdy = 1'($urandom_range(0, 1));
            r_br  = ($urandom_range(0, 17) == 0);
            r_hlt = ($urandom_range(0, 24) == 0);
            r_tgt = 10'($urandom_range(0, 1023));
            cycle(r_rst, r_st, r_ack, r_rdy, r_br, r_tgt, r_hlt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
